// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: digit width,
// FSM state encoding, add-3 correction constants and a 10^N-1 helper.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [DIGIT_W-1:0] CORR_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] CORR_ADD    = 4'd3;

  // Largest value representable with the given number of BCD digits.
  function automatic int unsigned bcd_max(input int unsigned digits);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake and result bus between a controller (master)
// and the bin2bcd_seq converter (slave).
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);

  logic                                start;
  logic [BIN_W-1:0]                    bin;
  logic                                busy;
  logic                                done;
  logic [bcd_pkg::DIGIT_W*DIGITS-1:0]  bcd;
  logic                                ovf;

  modport master (output start, bin, input busy, done, bcd, ovf);
  modport slave  (input start, bin, output busy, done, bcd, ovf);

endinterface

// File: rtl/bcd_add3.sv
// Single-digit double-dabble correction: digits of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= CORR_THRESH) ? (i_digit + CORR_ADD) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one operand bit per clock.
// Define BIN2BCD_OVF_EN to build the sticky overflow flag; otherwise ovf is tied 0.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  bin2bcd_seq_if.slave  bus
);

  localparam int WORK_W = DIGIT_W * DIGITS;
  localparam int CAT_W  = WORK_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t             r_state, w_stateNxt;
  logic [BIN_W-1:0]   r_bin, w_binNxt;
  logic [WORK_W-1:0]  r_work, w_workNxt;
  logic [WORK_W-1:0]  r_bcd, w_bcdNxt;
  logic [CNT_W-1:0]   r_cnt, w_cntNxt;
  logic               r_done, w_doneNxt;
  logic [WORK_W-1:0]  w_corr;
  logic [CAT_W-1:0]   w_shifted;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_add3 u_add3 (
        .i_digit (r_work[gi*DIGIT_W +: DIGIT_W]),
        .o_digit (w_corr[gi*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  // The bit leaving the top digit falls off the end of this shift.
  assign w_shifted = {w_corr, r_bin} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_work  <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_stateNxt;
      r_bin   <= w_binNxt;
      r_work  <= w_workNxt;
      r_bcd   <= w_bcdNxt;
      r_cnt   <= w_cntNxt;
      r_done  <= w_doneNxt;
    end
  end

  always_comb begin
    w_stateNxt = r_state;
    w_binNxt   = r_bin;
    w_workNxt  = r_work;
    w_bcdNxt   = r_bcd;
    w_cntNxt   = r_cnt;
    w_doneNxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_binNxt   = bus.bin;
          w_workNxt  = '0;
          w_cntNxt   = CNT_LOAD;
          w_stateNxt = SHIFT;
        end
      end
      SHIFT: begin
        {w_workNxt, w_binNxt} = w_shifted;
        w_cntNxt = r_cnt - CNT_LAST;
        if (r_cnt == CNT_LAST) begin
          w_bcdNxt   = w_shifted[CAT_W-1:BIN_W];
          w_doneNxt  = 1'b1;
          w_stateNxt = IDLE;
        end
      end
      default: w_stateNxt = IDLE;
    endcase
  end

`ifdef BIN2BCD_OVF_EN
  logic r_sticky, w_stickyNxt;
  logic r_ovf, w_ovfNxt;
  logic w_carry;

  assign w_carry = w_corr[WORK_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_sticky <= w_stickyNxt;
      r_ovf    <= w_ovfNxt;
    end
  end

  // Sticky flag collects every bit pushed out of the top digit during a run.
  always_comb begin
    w_stickyNxt = r_sticky;
    w_ovfNxt    = r_ovf;
    if (r_state == IDLE) begin
      if (bus.start) begin
        w_stickyNxt = 1'b0;
      end
    end else begin
      w_stickyNxt = r_sticky | w_carry;
      if (r_cnt == CNT_LAST) begin
        w_ovfNxt = r_sticky | w_carry;
      end
    end
  end

  assign bus.ovf = r_ovf;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.busy = (r_state == SHIFT);
  assign bus.done = r_done;
  assign bus.bcd  = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed vectors plus an arithmetic
// reference model compared every cycle against a 3-digit and a 2-digit instance.
module tb_bin2bcd_seq;
  import bcd_pkg::*;

  localparam int BIN_W = 8;
`ifdef BIN2BCD_OVF_EN
  localparam bit OVF_BUILT = 1'b1;
`else
  localparam bit OVF_BUILT = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] bin   = 8'd0;
  int         checks   = 0;
  int         failures = 0;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(3)) if3 ();
  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(2)) if2 ();

  assign if3.start = start;
  assign if3.bin   = bin;
  assign if2.start = start;
  assign if2.bin   = bin;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  always #5 clk = ~clk;

  // Decimal digits of v, least significant digit in the low nibble.
  function automatic logic [11:0] toBcd(input int unsigned v, input int unsigned digits);
    logic [11:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int unsigned i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic expOvf(input int unsigned v, input int unsigned d);
    return OVF_BUILT && (v > bcd_max(d));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: accept in idle, result appears BIN_W edges later.
  int          mCnt  = 0;
  logic [7:0]  mBin  = '0;
  logic        mDone = 1'b0;
  logic [11:0] mBcd3 = '0;
  logic [7:0]  mBcd2 = '0;
  logic        mOvf3 = 1'b0;
  logic        mOvf2 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mCnt  <= 0;
      mDone <= 1'b0;
      mBcd3 <= '0;
      mBcd2 <= '0;
      mOvf3 <= 1'b0;
      mOvf2 <= 1'b0;
    end else begin
      mDone <= 1'b0;
      if (mCnt == 0) begin
        if (start) begin
          mBin <= bin;
          mCnt <= BIN_W;
        end
      end else begin
        mCnt <= mCnt - 1;
        if (mCnt == 1) begin
          mDone <= 1'b1;
          mBcd3 <= toBcd(32'(mBin), 3);
          mBcd2 <= 8'(toBcd(32'(mBin), 2));
          mOvf3 <= expOvf(32'(mBin), 3);
          mOvf2 <= expOvf(32'(mBin), 2);
        end
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("busy3", 32'(if3.busy), 32'(mCnt != 0));
    checkOutput("done3", 32'(if3.done), 32'(mDone));
    checkOutput("bcd3",  32'(if3.bcd),  32'(mBcd3));
    checkOutput("ovf3",  32'(if3.ovf),  32'(mOvf3));
    checkOutput("busy2", 32'(if2.busy), 32'(mCnt != 0));
    checkOutput("done2", 32'(if2.done), 32'(mDone));
    checkOutput("bcd2",  32'(if2.bcd),  32'(mBcd2));
    checkOutput("ovf2",  32'(if2.ovf),  32'(mOvf2));
  end

  // Pulse start with v for one cycle, then wait (bounded) for done.
  task automatic applyStimulus(input logic [7:0] v, output int lat, output int busyCnt);
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    #1;
    start   = 1'b0;
    busyCnt = if3.busy ? 1 : 0;
    lat     = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (if3.done) break;
      if (if3.busy) busyCnt++;
    end
    checkOutput("doneSeen", 32'(if3.done), 32'd1);
  endtask

  task automatic waitDone(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!if3.done && n < 30);
    checkOutput("waitDone", 32'(if3.done), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, busyCnt, n1, n2, dones, doneAt;
    logic [11:0] capBcd;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    checkOutput("rstBusy", 32'(if3.busy), 32'd0);
    checkOutput("rstDone", 32'(if3.done), 32'd0);
    checkOutput("rstBcd",  32'(if3.bcd),  32'd0);
    checkOutput("rstOvf",  32'(if3.ovf),  32'd0);

    checkOutput("model255", 32'(toBcd(255, 3)), 32'h255);
    checkOutput("model150", 32'(toBcd(150, 2)), 32'h050);
    checkOutput("modelMax", bcd_max(3), 32'd999);

    applyStimulus(8'd255, lat, busyCnt);
    checkOutput("lat255",  lat,               32'd8);
    checkOutput("busy255", busyCnt,           32'd8);
    checkOutput("bcd255",  32'(if3.bcd),      32'h255);
    checkOutput("ovf255",  32'(if3.ovf),      32'd0);

    applyStimulus(8'd0, lat, busyCnt);
    checkOutput("bcd0", 32'(if3.bcd), 32'h000);
    applyStimulus(8'd99, lat, busyCnt);
    checkOutput("bcd99",  32'(if3.bcd), 32'h099);
    checkOutput("bcd2_99", 32'(if2.bcd), 32'h99);
    checkOutput("ovf2_99", 32'(if2.ovf), 32'd0);
    applyStimulus(8'd100, lat, busyCnt);
    checkOutput("bcd100", 32'(if3.bcd), 32'h100);
    applyStimulus(8'd150, lat, busyCnt);
    checkOutput("bcd2_150", 32'(if2.bcd), 32'h50);
    checkOutput("ovf2_150", 32'(if2.ovf), 32'(OVF_BUILT));

    // start held high: second conversion accepted on the edge after done
    start = 1'b1;
    bin   = 8'd5;
    waitDone(n1);
    waitDone(n2);
    start = 1'b0;
    checkOutput("b2bFirst",   n1,              32'd9);
    checkOutput("b2bSpacing", n2,              32'd9);
    checkOutput("b2bBcd",     32'(if3.bcd),    32'h005);
    repeat (3) @(posedge clk);
    #1;

    // start pulsed mid-conversion must be ignored
    start = 1'b1;
    bin   = 8'd200;
    @(posedge clk);
    #1;
    dones  = 0;
    doneAt = 0;
    capBcd = '0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) begin
        start = 1'b1;
        bin   = 8'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (if3.done) begin
        dones++;
        doneAt = c;
        capBcd = if3.bcd;
      end
    end
    checkOutput("ignDones", dones,       32'd1);
    checkOutput("ignAt",    doneAt,      32'd8);
    checkOutput("ignBcd",   32'(capBcd), 32'h200);

    // reset in the middle of a conversion aborts it
    start = 1'b1;
    bin   = 8'd173;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abortBusy", 32'(if3.busy), 32'd0);
    checkOutput("abortBcd",  32'(if3.bcd),  32'h000);
    checkOutput("abortDone", 32'(if3.done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    dones = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (if3.done) dones++;
    end
    checkOutput("abortNoDone", dones, 32'd0);
    applyStimulus(8'd42, lat, busyCnt);
    checkOutput("bcd42", 32'(if3.bcd), 32'h042);

    for (int v = 0; v < 256; v++) begin
      applyStimulus(8'(v), lat, busyCnt);
      checkOutput("sweepLat", lat, 32'd8);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double-dabble), one bit per clock. It produces packed BCD digits from a binary operand, for the seven-segment display path and the BCD adder datapath. A start/busy/done handshake lets a controller request one conversion at a time. The result is held stable between conversions.

## Interface
- `BIN_W`, default 8: binary operand width; equals the number of shift cycles.
- `DIGITS`, default 3: number of BCD output digits, 4 bits each.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
  - One clock; reset is asynchronous and active-low.
- `start` input 1: conversion request, sampled on `clk` only in IDLE.
- `bin` input BIN_W: unsigned binary operand, sampled together with `start`.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: one-cycle pulse when `bcd` is updated.
- `bcd` output 4*DIGITS: packed result; digit 0 is the least significant, in `bcd[3:0]`.
- `ovf` output 1: operand exceeded 10^DIGITS−1; valid with `done`, held until the next `done`.

## Operation
- FSM states: IDLE, SHIFT.
- **Reset:** state=IDLE, `busy`=0, `done`=0, `bcd`=0, `ovf`=0, internal shift registers and counter=0.
- **IDLE:** if `start`=1 at an edge:
  - latch `bin` into the binary shift register;
  - clear the BCD working register and the sticky overflow bit;
  - counter=BIN_W, `busy`=1, go to SHIFT.
- **SHIFT**, each edge:
  - every working digit ≥5 gets +3 (4-bit, no carry between digits);
  - then shift {BCD working, binary} left one bit, with the binary MSB entering digit 0 LSB;
  - the bit shifted out of the top digit ORs into sticky overflow;
  - counter decrements.
- **Last shift (counter=1):** in the same edge:
  - load the post-shift working value into `bcd`;
  - load sticky overflow into `ovf`;
  - `done`=1, `busy`=0, go to IDLE.
- `done` is high for exactly one cycle, then 0.
- `start` during SHIFT is ignored; no queuing.
- `bin` changes during SHIFT have no effect.
- `bcd` and `ovf` change only on the completing edge or on reset.
- Reset mid-conversion aborts: all outputs return to reset values and no `done` is issued.
- With BIN_W=8 and DIGITS=3, overflow cannot occur.
- Digit correction threshold is fixed at ≥5. Digits never exceed 9 after any step for legal widths.

## Timing
- Start sampled at edge E0; shifts occur at E1…E_BIN_W.
- `done` and the new `bcd` are visible after E_BIN_W.
- Latency: BIN_W cycles from start sample to `done`. Default is 8.
- `busy` is high from after E0 until after E_BIN_W.
- `start` held high while `done`=1 is accepted at the next edge.
- Maximum throughput: one conversion per BIN_W+1 cycles.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `BIN2BCD_OVF_EN` defined:
  - sticky overflow logic is built;
  - `ovf` reports overflow as described above.
- `BIN2BCD_OVF_EN` undefined:
  - no overflow logic is built;
  - `ovf` is tied to 0;
  - bits shifted out of the top digit are discarded;
  - `bcd` holds the low DIGITS digits of the true value.

## Structure
- Shared package `bcd_pkg` holds:
  - `DIGIT_W`=4;
  - state encoding IDLE/SHIFT;
  - correction constants (threshold 5, addend 3);
  - function `bcd_max(DIGITS)` returning 10^DIGITS−1, for bench checking.
- Sub-module `bcd_add3`: 4-bit combinational digit correction (in ≥5 ? in+3 : in), instantiated DIGITS times via generate.

## Test plan
- Reset, then `bin`=255 with `start` for one cycle: `busy` high for 8 cycles; `done` pulses 8 cycles after the start sample; `bcd`=12'h255, `ovf`=0.
- `bin`=0 → `bcd`=12'h000. `bin`=99 → 12'h099. `bin`=100 → 12'h100. Back-to-back with `start` held high gives 9-cycle spacing between `done` pulses.
- Start 200, then pulse `start` with `bin`=7 at shift cycle 3: ignored; result is 12'h200 at the original time, with exactly one `done` pulse.
- Start 173, assert `rst_n`=0 at shift cycle 4:
  - immediate `busy`=0, `bcd`=0, no `done`;
  - after release, `bin`=42 converts to 12'h042.
- DIGITS=2, `BIN2BCD_OVF_EN` defined, `bin`=150 → `ovf`=1, `bcd`=8'h50. Then `bin`=99 → `ovf`=0, `bcd`=8'h99.
- Exhaustive sweep 0…255 at default parameters: `bcd` equals the decimal digits of `bin` on every `done`.
